// File: rtl/bulk_ep_ctrl_mc.sv
// Multi-channel bulk endpoint controller.
// Passes NUM_CHAN bulk IN/OUT streams between the transaction layer and the
// endpoints, generates OUT tlast per channel from a programmable packet length,
// keeps per-channel status flags and serves vendor control requests.
//
// state       | meaning
// ------------+------------------------------------------------------------
// S_IDLE      | waiting for ctl_xfer; decodes the request on the next edge
// S_CFG_GET   | streaming the 6-byte configuration image (min(6,wLength))
// S_REG_READ  | streaming a 16-bit register, LSB first
// S_REG_WRITE | collecting two host-to-device bytes, LSB first
// S_WAIT      | done asserted until the host drops ctl_xfer
module bulk_ep_ctrl_mc #(
  parameter int          NUM_CHAN    = 2,
  parameter bit          HIGH_SPEED  = 1'b1,
  parameter bit          PACKET_MODE = 1'b1,
  parameter logic [31:0] CONFIG_CHAN = 32'h0,
  parameter logic [15:0] DEFAULT_TLR = 16'd512
) (
  input  logic                  clk,
  input  logic                  rst_n,
  // control transfer interface
  input  logic [3:0]            ctl_xfer_endpoint,
  input  logic [7:0]            ctl_xfer_type,
  input  logic [7:0]            ctl_xfer_request,
  input  logic [15:0]           ctl_xfer_value,
  input  logic [15:0]           ctl_xfer_index,
  input  logic [15:0]           ctl_xfer_length,
  input  logic                  ctl_xfer,
  output logic                  ctl_xfer_accept,
  output logic                  ctl_xfer_done,
  input  logic [7:0]            ctl_xfer_data_out,
  input  logic                  ctl_xfer_data_out_valid,
  output logic [7:0]            ctl_xfer_data_in,
  output logic                  ctl_xfer_data_in_valid,
  output logic                  ctl_xfer_data_in_last,
  input  logic                  ctl_xfer_data_in_ready,
  // bulk OUT (host to device), transaction layer side
  output logic [NUM_CHAN-1:0]   tlp_blk_xfer_out_ready_read,
  input  logic [NUM_CHAN*8-1:0] tlp_blk_xfer_out_data,
  input  logic [NUM_CHAN-1:0]   tlp_blk_xfer_out_data_valid,
  output logic [NUM_CHAN-1:0]   tlp_blk_xfer_out_data_ready,
  // bulk OUT, endpoint side
  input  logic [NUM_CHAN-1:0]   ep_blk_xfer_out_ready_read,
  output logic [NUM_CHAN*8-1:0] ep_blk_xfer_out_data,
  output logic [NUM_CHAN-1:0]   ep_blk_xfer_out_data_valid,
  input  logic [NUM_CHAN-1:0]   ep_blk_xfer_out_data_ready,
  output logic [NUM_CHAN-1:0]   ep_blk_xfer_out_data_last,
  // bulk IN (device to host), transaction layer side
  output logic [NUM_CHAN-1:0]   tlp_blk_xfer_in_has_data,
  output logic [NUM_CHAN*8-1:0] tlp_blk_xfer_in_data,
  output logic [NUM_CHAN-1:0]   tlp_blk_xfer_in_data_valid,
  output logic [NUM_CHAN-1:0]   tlp_blk_xfer_in_data_last,
  input  logic [NUM_CHAN-1:0]   tlp_blk_xfer_in_data_ready,
  // bulk IN, endpoint side
  input  logic [NUM_CHAN-1:0]   ep_blk_xfer_in_has_data,
  input  logic [NUM_CHAN*8-1:0] ep_blk_xfer_in_data,
  input  logic [NUM_CHAN-1:0]   ep_blk_xfer_in_data_valid,
  input  logic [NUM_CHAN-1:0]   ep_blk_xfer_in_data_last,
  output logic [NUM_CHAN-1:0]   ep_blk_xfer_in_data_ready
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CFG_GET,
    S_REG_READ,
    S_REG_WRITE,
    S_WAIT
  } state_t;

  localparam logic [7:0]  REQ_CFG_GET    = 8'd0;
  localparam logic [7:0]  REQ_REG_OPER   = 8'd1;
  localparam logic [7:0]  REQ_CHAN_RESET = 8'd2;
  localparam logic [3:0]  NUM_CHAN_L     = 4'(NUM_CHAN);
  localparam logic [47:0] CFG_IMG        = {8'(NUM_CHAN), 6'b0, PACKET_MODE, HIGH_SPEED, CONFIG_CHAN};

  state_t              state_q, state_d;
  logic                accept_q, accept_d;
  logic [2:0]          idx_q, idx_d;
  logic [2:0]          len_q;
  logic [1:0]          addr_q;
  logic [2:0]          chan_q;
  logic [15:0]         rd_val_q;
  logic [7:0]          wr_lo_q;

  logic [15:0]         cnt_q [NUM_CHAN];
  logic [15:0]         tlr_q [NUM_CHAN];
  logic [NUM_CHAN-1:0] tsr_rdy_q, tsr_lst_q, rsr_rdy_q, rsr_lst_q;

  logic [NUM_CHAN-1:0] out_beat, in_beat, at_end;
  logic [NUM_CHAN-1:0] tsr_rdy_set, tsr_lst_set, rsr_rdy_set, rsr_lst_set;
  logic [NUM_CHAN-1:0] tsr_rdy_clr, tsr_lst_clr, rsr_rdy_clr, rsr_lst_clr;
  logic [NUM_CHAN-1:0] tlr_we, chan_rst;

  logic                dir_in, req_cfg, req_reg, req_rst;
  logic                addr_ok, chan_ok, decode;
  logic [2:0]          cfg_len;
  logic [15:0]         reg_rd_val;
  logic                wr_lo_stb, wr_hi_stb;
  logic [47:0]         cfg_sh;
  logic                unused_bits;

  // Bulk streams are wired straight through; only OUT tlast is generated here.
  assign tlp_blk_xfer_out_ready_read = ep_blk_xfer_out_ready_read;
  assign ep_blk_xfer_out_data        = tlp_blk_xfer_out_data;
  assign ep_blk_xfer_out_data_valid  = tlp_blk_xfer_out_data_valid;
  assign tlp_blk_xfer_out_data_ready = ep_blk_xfer_out_data_ready;
  assign tlp_blk_xfer_in_has_data    = ep_blk_xfer_in_has_data;
  assign tlp_blk_xfer_in_data        = ep_blk_xfer_in_data;
  assign tlp_blk_xfer_in_data_valid  = ep_blk_xfer_in_data_valid;
  assign tlp_blk_xfer_in_data_last   = ep_blk_xfer_in_data_last;
  assign ep_blk_xfer_in_data_ready   = tlp_blk_xfer_in_data_ready;

  assign out_beat = tlp_blk_xfer_out_data_valid & ep_blk_xfer_out_data_ready;
  assign in_beat  = ep_blk_xfer_in_data_valid & tlp_blk_xfer_in_data_ready;

  // TLR=0 makes TLR-1 all ones, so the counter wraps naturally and last stays low.
  genvar gc;
  for (gc = 0; gc < NUM_CHAN; gc++) begin : g_last
    assign at_end[gc] = (cnt_q[gc] == tlr_q[gc] - 16'd1);
    assign ep_blk_xfer_out_data_last[gc] = PACKET_MODE && (tlr_q[gc] != 16'd0) && at_end[gc];
  end

  assign tsr_rdy_set = ep_blk_xfer_out_ready_read & ep_blk_xfer_out_data_ready;
  assign tsr_lst_set = {NUM_CHAN{PACKET_MODE}} & out_beat & ep_blk_xfer_out_data_last;
  assign rsr_rdy_set = ep_blk_xfer_in_has_data & ep_blk_xfer_in_data_valid;
  assign rsr_lst_set = {NUM_CHAN{PACKET_MODE}} & in_beat & ep_blk_xfer_in_data_last;

  assign dir_in  = ctl_xfer_type[7];
  assign req_cfg = (ctl_xfer_request == REQ_CFG_GET);
  assign req_reg = (ctl_xfer_request == REQ_REG_OPER);
  assign req_rst = (ctl_xfer_request == REQ_CHAN_RESET);
  assign addr_ok = (ctl_xfer_value[7:0] <= 8'd3);
  assign chan_ok = ({1'b0, ctl_xfer_index[2:0]} < NUM_CHAN_L);
  assign cfg_len = (ctl_xfer_length >= 16'd6) ? 3'd6 : ctl_xfer_length[2:0];
  assign decode  = (state_q == S_IDLE) && ctl_xfer;

  assign wr_lo_stb = (state_q == S_REG_WRITE) && ctl_xfer_data_out_valid && (idx_q == 3'd0);
  assign wr_hi_stb = (state_q == S_REG_WRITE) && ctl_xfer_data_out_valid && (idx_q == 3'd1);

  assign unused_bits = ^{ctl_xfer_endpoint, ctl_xfer_type[6:0], ctl_xfer_value[15:8],
                         ctl_xfer_index[15:3]};

  // Register selected by the live request fields, captured into rd_val_q on decode.
  always_comb begin
    reg_rd_val = 16'h0000;
    for (int c = 0; c < NUM_CHAN; c++) begin
      if (ctl_xfer_index[2:0] == 3'(c)) begin
        case (ctl_xfer_value[1:0])
          2'd0:    reg_rd_val = {14'b0, tsr_lst_q[c], tsr_rdy_q[c]};
          2'd1:    reg_rd_val = tlr_q[c];
          2'd2:    reg_rd_val = {14'b0, rsr_lst_q[c], rsr_rdy_q[c]};
          default: reg_rd_val = cnt_q[c];
        endcase
      end
    end
  end

  // Per-channel write-enables and clears derived from control requests.
  always_comb begin
    tsr_rdy_clr = '0;
    tsr_lst_clr = '0;
    rsr_rdy_clr = '0;
    rsr_lst_clr = '0;
    tlr_we      = '0;
    chan_rst    = '0;
    if (decode && req_rst) chan_rst = ctl_xfer_value[NUM_CHAN-1:0];
    for (int c = 0; c < NUM_CHAN; c++) begin
      if (chan_q == 3'(c)) begin
        if (wr_lo_stb && addr_q == 2'd0) begin
          tsr_rdy_clr[c] = ctl_xfer_data_out[0];
          tsr_lst_clr[c] = ctl_xfer_data_out[1];
        end
        if (wr_lo_stb && addr_q == 2'd2) begin
          rsr_rdy_clr[c] = ctl_xfer_data_out[0];
          rsr_lst_clr[c] = ctl_xfer_data_out[1];
        end
        if (wr_hi_stb && addr_q == 2'd1) tlr_we[c] = 1'b1;
      end
    end
  end

  // Next-state logic; accept is registered so a reject shows accept=0 with done=1.
  always_comb begin
    state_d  = state_q;
    accept_d = accept_q;
    idx_d    = idx_q;
    case (state_q)
      S_IDLE: begin
        accept_d = 1'b0;
        idx_d    = 3'd0;
        if (ctl_xfer) begin
          state_d = S_WAIT;
          if (req_cfg && dir_in) begin
            accept_d = 1'b1;
            if (cfg_len != 3'd0) state_d = S_CFG_GET;
          end else if (req_reg && addr_ok && chan_ok && (dir_in || ctl_xfer_value[1:0] != 2'd3)) begin
            accept_d = 1'b1;
            state_d  = dir_in ? S_REG_READ : S_REG_WRITE;
          end else if (req_rst) begin
            accept_d = 1'b1;
          end
        end
      end
      S_CFG_GET: begin
        if (ctl_xfer_data_in_ready) begin
          if (idx_q == len_q - 3'd1) state_d = S_WAIT;
          else                       idx_d   = idx_q + 3'd1;
        end
      end
      S_REG_READ: begin
        if (ctl_xfer_data_in_ready) begin
          if (idx_q == 3'd1) state_d = S_WAIT;
          else               idx_d   = idx_q + 3'd1;
        end
      end
      S_REG_WRITE: begin
        if (ctl_xfer_data_out_valid) begin
          if (idx_q == 3'd1) state_d = S_WAIT;
          else               idx_d   = idx_q + 3'd1;
        end
      end
      S_WAIT: begin
        if (!ctl_xfer) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      accept_q <= 1'b0;
      idx_q    <= 3'd0;
    end else begin
      state_q  <= state_d;
      accept_q <= accept_d;
      idx_q    <= idx_d;
    end
  end

  // Request fields captured at decode, low write byte held until the high byte arrives.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_q    <= 3'd0;
      addr_q   <= 2'd0;
      chan_q   <= 3'd0;
      rd_val_q <= 16'h0000;
      wr_lo_q  <= 8'h00;
    end else begin
      if (decode) begin
        len_q    <= cfg_len;
        addr_q   <= ctl_xfer_value[1:0];
        chan_q   <= ctl_xfer_index[2:0];
        rd_val_q <= reg_rd_val;
      end
      if (wr_lo_stb) wr_lo_q <= ctl_xfer_data_out;
    end
  end

  // Per-channel counters, packet lengths and status flags (a set beats a same-cycle clear).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < NUM_CHAN; c++) begin
        cnt_q[c] <= 16'h0000;
        tlr_q[c] <= DEFAULT_TLR;
      end
      tsr_rdy_q <= '0;
      tsr_lst_q <= '0;
      rsr_rdy_q <= '0;
      rsr_lst_q <= '0;
    end else begin
      for (int c = 0; c < NUM_CHAN; c++) begin
        if (tlr_we[c]) tlr_q[c] <= {ctl_xfer_data_out, wr_lo_q};
        if (chan_rst[c]) begin
          cnt_q[c]     <= 16'h0000;
          tsr_rdy_q[c] <= 1'b0;
          tsr_lst_q[c] <= 1'b0;
          rsr_rdy_q[c] <= 1'b0;
          rsr_lst_q[c] <= 1'b0;
        end else begin
          if (tlr_we[c])        cnt_q[c] <= 16'h0000;
          else if (out_beat[c]) cnt_q[c] <= at_end[c] ? 16'h0000 : cnt_q[c] + 16'd1;
          tsr_rdy_q[c] <= tsr_rdy_set[c] | (tsr_rdy_q[c] & ~tsr_rdy_clr[c]);
          tsr_lst_q[c] <= tsr_lst_set[c] | (tsr_lst_q[c] & ~tsr_lst_clr[c]);
          rsr_rdy_q[c] <= rsr_rdy_set[c] | (rsr_rdy_q[c] & ~rsr_rdy_clr[c]);
          rsr_lst_q[c] <= rsr_lst_set[c] | (rsr_lst_q[c] & ~rsr_lst_clr[c]);
        end
      end
    end
  end

  // Control outputs decoded from the state so reset clears them immediately.
  always_comb begin
    cfg_sh                 = CFG_IMG >> {idx_q, 3'b000};
    ctl_xfer_accept        = accept_q;
    ctl_xfer_done          = (state_q == S_WAIT);
    ctl_xfer_data_in       = 8'h00;
    ctl_xfer_data_in_valid = 1'b0;
    ctl_xfer_data_in_last  = 1'b0;
    if (state_q == S_CFG_GET) begin
      ctl_xfer_data_in       = cfg_sh[7:0];
      ctl_xfer_data_in_valid = 1'b1;
      ctl_xfer_data_in_last  = (idx_q == len_q - 3'd1);
    end else if (state_q == S_REG_READ) begin
      ctl_xfer_data_in       = (idx_q == 3'd0) ? rd_val_q[7:0] : rd_val_q[15:8];
      ctl_xfer_data_in_valid = 1'b1;
      ctl_xfer_data_in_last  = (idx_q == 3'd1);
    end
  end

endmodule
